// File: rtl/dcpu_busram.sv
// Single-port word RAM slave with IDLE/WAIT/ACK handshake and WS programmable wait states.
// Optional doorbell interrupt on the top local word: define DCPU_BUSRAM_DOORBELL_EN.
module dcpu_busram #(
  parameter int unsigned    W    = 16,
  parameter int unsigned    AW   = 10,
  parameter logic [W-1:0]   BASE = '0,
  parameter int unsigned    WS   = 0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_cs,
  input  logic         i_we,
  input  logic [W-1:0] i_addr,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat,
  output logic         o_ack,
  output logic         o_irq
);

  localparam logic [3:0] WS_L = 4'(WS);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           we_q, we_d;
  logic [W-1:0]   wdat_q, wdat_d;
  logic [W-1:0]   dat_q;
  logic           ack_q;
  logic [W-1:0]   mem [2**AW];

  logic           hit;
  logic           go_ack;
  logic [AW-1:0]  acc_addr;
  logic           acc_we;
  logic [W-1:0]   acc_dat;

  assign hit = i_cs && (i_addr[W-1:AW] == BASE[W-1:AW]);

  // With WS=0 the access completes on the capture edge, so the array is
  // addressed straight from the inputs instead of the capture registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdat_d   = wdat_q;
    go_ack   = 1'b0;
    acc_addr = addr_q;
    acc_we   = we_q;
    acc_dat  = wdat_q;
    case (state_q)
      IDLE: begin
        if (hit) begin
          addr_d = i_addr[AW-1:0];
          we_d   = i_we;
          wdat_d = i_dat;
          cnt_d  = WS_L;
          if (WS_L == 4'd0) begin
            go_ack   = 1'b1;
            acc_addr = i_addr[AW-1:0];
            acc_we   = i_we;
            acc_dat  = i_dat;
            state_d  = ACK;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!i_cs) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          cnt_d   = '0;
          go_ack  = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
      ack_q   <= go_ack;
      if (go_ack && !acc_we) dat_q <= mem[acc_addr];
    end
  end

  // Array has no reset; the reset term only blocks a write landing while reset is held.
  always_ff @(posedge i_clk) begin
    if (go_ack && acc_we && !i_reset) mem[acc_addr] <= acc_dat;
  end

  assign o_dat = dat_q;
  assign o_ack = ack_q;

`ifdef DCPU_BUSRAM_DOORBELL_EN
  logic irq_q;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                        irq_q <= 1'b0;
    else if (go_ack && (acc_addr == '1)) irq_q <= acc_we;
  end
  assign o_irq = irq_q;
`else
  assign o_irq = 1'b0;
`endif

endmodule

// File: doc/dcpu_busram.md
DCPU_BUSRAM -- requirements
Module: dcpu_busram

Interface
REQ-001 SHALL provide parameter W, default 16, bus data and address width in bits.
REQ-002 SHALL provide parameter AW, default 10, local word-address width; the array holds 2^AW words.
REQ-003 SHALL provide parameter BASE, default 0, W-bit base address; only bits [W-1:AW] are used.
REQ-004 SHALL provide parameter WS, default 0, range 0..15, wait states inserted before o_ack.
REQ-005 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-006 i_reset  input  1  asynchronous, active-high reset.
REQ-007 i_cs  input  1  request valid from the initiator.
REQ-008 i_we  input  1  1 = write, 0 = read; qualified by i_cs.
REQ-009 i_addr  input  W  word address.
REQ-010 i_dat  input  W  write data.
REQ-011 o_dat  output  W  read data, registered.
REQ-012 o_ack  output  1  one-cycle completion strobe, registered.
REQ-013 o_irq  output  1  doorbell interrupt, registered; present in both builds.

Function
REQ-014 SHALL select the block when i_cs=1 and i_addr[W-1:AW]==BASE[W-1:AW] (hit); non-hits SHALL be ignored with no state change.
REQ-015 SHALL implement states IDLE, WAIT and ACK.
REQ-016 IDLE: on an edge with a hit, SHALL capture i_addr[AW-1:0], i_we and i_dat, load the wait counter with WS, and go to WAIT if WS>0, otherwise to ACK.
REQ-017 WAIT: SHALL decrement the counter each edge and go to ACK on the edge where the counter reads 1.
REQ-018 WAIT: if i_cs=0 at an edge, SHALL abort to IDLE with no write, no ack and no o_dat change.
REQ-019 On the edge entering ACK: a write SHALL store the captured data at the captured address; a read SHALL load o_dat from that address.
REQ-020 ACK: o_ack=1 for exactly one cycle, then IDLE unconditionally; inputs during the ACK cycle SHALL NOT be captured.
REQ-021 Latency: the first cycle of a hit in IDLE is cycle 0; o_ack SHALL be high in cycle 1+WS. Back-to-back period SHALL be 2+WS cycles with i_cs held high continuously.
REQ-022 o_dat SHALL hold its last read value during writes and idle cycles.
REQ-023 o_ack SHALL never be high in two consecutive cycles.
REQ-024 Write followed by read of the same address SHALL return the new data, with no bypass hazard.

Reset
REQ-025 i_reset=1 SHALL force, asynchronously: state IDLE, counter 0, o_ack=0, o_dat=0, o_irq=0.
REQ-026 Reset during WAIT or ACK SHALL drop the transaction; a pending write SHALL NOT be stored.
REQ-027 Array contents SHALL NOT be reset.

Configuration
REQ-028 Macro DCPU_BUSRAM_DOORBELL_EN SHALL control the doorbell at local address 2^AW-1.
REQ-029 With the macro defined: a write there SHALL also set o_irq=1 on ACK entry; a read there SHALL clear o_irq on ACK entry; the word is still stored and read normally.
REQ-030 Without the macro: o_irq SHALL be constant 0 and address 2^AW-1 SHALL be an ordinary word.

Verification
REQ-031 WS=0: write 0x1234 to 0x0005, then read 0x0005 -> o_ack in cycle 1 of each access; read o_dat=0x1234.
REQ-032 WS=3: read 0x0002 with i_cs held high -> o_ack in cycle 4 only; o_ack=0 in cycles 1-3 and 5; next request captured in cycle 5, acked in cycle 9.
REQ-033 BASE=0x0400, AW=10: access to 0x0005 -> no ack for 20 cycles; access to 0x0405 -> acked, hitting local word 5.
REQ-034 WS=5: write 0xBEEF to 0x0010, deassert i_cs after 2 cycles, then read 0x0010 -> no ack for the aborted write; read returns the prior value.
REQ-035 WS=4: assert i_reset in the second WAIT cycle of a write of 0xAAAA to 0x0003 -> o_ack=0 and o_dat=0 immediately; a later read of 0x0003 returns the old value.
REQ-036 With DCPU_BUSRAM_DOORBELL_EN, AW=10: write 0x0001 to 0x03FF -> o_irq=1 from the ack cycle; read 0x03FF -> o_dat=0x0001, o_irq=0 from the ack cycle. Without the macro -> o_irq stays 0.
